// File: rtl/fa_modport_if.sv
// fa_modport_if: operand/result bundle for the fa_modport adder.
//   a, b      : WIDTH-bit operands            (dut_mp in,  tb_mp out)
//   c         : carry-in                      (dut_mp in,  tb_mp out)
//   in_valid  : qualifies a/b/c for the register stage
//   sum/carry : combinational result          (dut_mp out, tb_mp in)
//   sum_q/carry_q/out_valid : registered result and its valid flag
interface fa_if #(parameter int WIDTH = 1) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             out_valid;
    modport dut_mp (
        input  a, b, c, in_valid,
        output sum, carry, sum_q, carry_q, out_valid
    );
    modport tb_mp (
        output a, b, c, in_valid,
        input  sum, carry, sum_q, carry_q, out_valid
    );
endinterface

// File: rtl/fa_modport.sv
// fa_modport: WIDTH-bit ripple-carry full adder with combinational and registered outputs.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears the registered result)
//   fa  : fa_if bundle, DUT side; a + b + c -> {carry, sum}, and {carry_q, sum_q, out_valid}
module fa_modport #(
    parameter int WIDTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    fa_if.dut_mp  fa
);
    // w_k[i] is the carry into cell i; w_k[WIDTH] is the carry out of the chain
    logic [WIDTH:0]   w_k;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_sum_q;
    logic             r_carry_q;
    logic             r_out_valid;

    assign w_k[0] = fa.c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign w_s[i]   = fa.a[i] ^ fa.b[i] ^ w_k[i];
        assign w_k[i+1] = (fa.a[i] & fa.b[i]) | (fa.b[i] & w_k[i]) | (w_k[i] & fa.a[i]);
    end

    assign fa.sum   = w_s;
    assign fa.carry = w_k[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_q     <= '0;
            r_carry_q   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= fa.in_valid;
            if (fa.in_valid) begin
                r_sum_q   <= w_s;
                r_carry_q <= w_k[WIDTH];
            end
        end
    end

    assign fa.sum_q     = r_sum_q;
    assign fa.carry_q   = r_carry_q;
    assign fa.out_valid = r_out_valid;
endmodule

// File: tb/tb_fa_modport.sv
// tb_fa_modport: table-driven and randomized checks of fa_modport at WIDTH=1 and WIDTH=8.
module tb_fa_modport;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fa_if #(.WIDTH(1)) if1 ();
    fa_if #(.WIDTH(8)) if8 ();

    fa_modport #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .fa(if1.dut_mp));
    fa_modport #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .fa(if8.dut_mp));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic a, b, c;
        logic s, co;
    } vec1_t;

    typedef struct packed {
        logic [7:0] a, b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec8_t;

    vec1_t seq1 [5];
    vec1_t all1 [8];
    vec8_t tab8 [4];

    // reference state for the registered path
    logic [7:0] m_sum;
    logic       m_carry;
    logic       m_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // checks the 8-bit combinational outputs against plain arithmetic
    task automatic chk_comb8(input string name);
        logic [8:0] full;
        full = {1'b0, if8.a} + {1'b0, if8.b} + {8'd0, if8.c};
        chk({name, "_sum"}, 64'(if8.sum), 64'(full[7:0]));
        chk({name, "_carry"}, 64'(if8.carry), 64'(full[8]));
    endtask

    // advances one clock, updates the reference from the values driven at that edge, then compares
    task automatic step(input string name);
        logic [8:0] full;
        full = {1'b0, if8.a} + {1'b0, if8.b} + {8'd0, if8.c};
        if (rst) begin
            m_sum = 8'h00; m_carry = 1'b0; m_valid = 1'b0;
        end else if (if8.in_valid) begin
            m_sum = full[7:0]; m_carry = full[8]; m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({name, "_sum_q"}, 64'(if8.sum_q), 64'(m_sum));
        chk({name, "_carry_q"}, 64'(if8.carry_q), 64'(m_carry));
        chk({name, "_out_valid"}, 64'(if8.out_valid), 64'(m_valid));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if1.a = '0; if1.b = '0; if1.c = 1'b0; if1.in_valid = 1'b0;
        if8.a = '0; if8.b = '0; if8.c = 1'b0; if8.in_valid = 1'b0;
        m_sum = 8'h00; m_carry = 1'b0; m_valid = 1'b0;

        seq1[0] = '{a:0, b:0, c:0, s:0, co:0};
        seq1[1] = '{a:0, b:0, c:1, s:1, co:0};
        seq1[2] = '{a:0, b:1, c:1, s:0, co:1};
        seq1[3] = '{a:1, b:1, c:0, s:0, co:1};
        seq1[4] = '{a:1, b:1, c:1, s:1, co:1};

        all1[0] = '{a:0, b:0, c:0, s:0, co:0};
        all1[1] = '{a:0, b:0, c:1, s:1, co:0};
        all1[2] = '{a:0, b:1, c:0, s:1, co:0};
        all1[3] = '{a:0, b:1, c:1, s:0, co:1};
        all1[4] = '{a:1, b:0, c:0, s:1, co:0};
        all1[5] = '{a:1, b:0, c:1, s:0, co:1};
        all1[6] = '{a:1, b:1, c:0, s:0, co:1};
        all1[7] = '{a:1, b:1, c:1, s:1, co:1};

        tab8[0] = '{a:8'hFF, b:8'h01, c:0, s:8'h00, co:1};
        tab8[1] = '{a:8'hFF, b:8'hFF, c:1, s:8'hFF, co:1};
        tab8[2] = '{a:8'h12, b:8'h34, c:1, s:8'h47, co:0};
        tab8[3] = '{a:8'h80, b:8'h80, c:0, s:8'h00, co:1};

        // combinational path works while rst is high
        for (int i = 0; i < 5; i++) begin
            if1.a = seq1[i].a; if1.b = seq1[i].b; if1.c = seq1[i].c;
            #1;
            chk($sformatf("seq1_%0d_sum", i), 64'(if1.sum), 64'(seq1[i].s));
            chk($sformatf("seq1_%0d_carry", i), 64'(if1.carry), 64'(seq1[i].co));
        end
        for (int i = 0; i < 8; i++) begin
            if1.a = all1[i].a; if1.b = all1[i].b; if1.c = all1[i].c;
            #1;
            chk($sformatf("all1_%0d_sum", i), 64'(if1.sum), 64'(all1[i].s));
            chk($sformatf("all1_%0d_carry", i), 64'(if1.carry), 64'(all1[i].co));
        end
        for (int i = 0; i < 4; i++) begin
            if8.a = tab8[i].a; if8.b = tab8[i].b; if8.c = tab8[i].c;
            #1;
            chk($sformatf("tab8_%0d_sum", i), 64'(if8.sum), 64'(tab8[i].s));
            chk($sformatf("tab8_%0d_carry", i), 64'(if8.carry), 64'(tab8[i].co));
        end

        // reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum_q", 64'(if8.sum_q), 64'h00);
        chk("rst_carry_q", 64'(if8.carry_q), 64'h0);
        chk("rst_out_valid", 64'(if8.out_valid), 64'h0);

        // first valid result
        rst = 1'b0;
        if8.a = 8'h12; if8.b = 8'h34; if8.c = 1'b1; if8.in_valid = 1'b1;
        step("first");
        chk("first_sum_q_const", 64'(if8.sum_q), 64'h47);

        // hold when in_valid drops
        if8.a = 8'hAA; if8.b = 8'h55; if8.c = 1'b1; if8.in_valid = 1'b0;
        step("hold");
        chk("hold_sum_q_const", 64'(if8.sum_q), 64'h47);
        chk("hold_out_valid_const", 64'(if8.out_valid), 64'h0);

        // three back-to-back valid inputs
        for (int i = 0; i < 3; i++) begin
            if8.a = 8'(8'h10 * (i + 1)); if8.b = 8'(8'hF0 + i); if8.c = 1'(i); if8.in_valid = 1'b1;
            step($sformatf("b2b_%0d", i));
        end

        // reset beats a simultaneous valid input
        rst = 1'b1;
        if8.a = 8'h80; if8.b = 8'h80; if8.c = 1'b0; if8.in_valid = 1'b1;
        step("rst_prio");
        chk("rst_prio_out_valid_const", 64'(if8.out_valid), 64'h0);
        rst = 1'b0;

        // randomized stimulus
        for (int n = 0; n < 300; n++) begin
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            if8.c = 1'($urandom);
            if8.in_valid = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 15) == 0);
            if1.a = 1'($urandom); if1.b = 1'($urandom); if1.c = 1'($urandom);
            #1;
            chk_comb8("rnd_comb8");
            chk("rnd1_sum", 64'(if1.sum), 64'(if1.a ^ if1.b ^ if1.c));
            chk("rnd1_carry", 64'(if1.carry), 64'((32'(if1.a) + 32'(if1.b) + 32'(if1.c)) >= 2));
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
